// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU sequencing front end.
// Optional result flags are enabled by defining ALU_SEQ_FLAGS_EN.
package alu_seq_pkg;

  localparam int DEF_NREGS = 8;
  localparam int DEF_W     = 8;
  localparam int OP_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // ALU opcode map; the sequencer passes these through without decoding.
  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd7;
  localparam logic [OP_W-1:0] OP_PASSA = 4'd8;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd9;
  localparam logic [OP_W-1:0] OP_SHL   = 4'd10;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd11;
  localparam logic [OP_W-1:0] OP_SRA   = 4'd12;
  localparam logic [OP_W-1:0] OP_INC4  = 4'd13;
  localparam logic [OP_W-1:0] OP_DEC4  = 4'd14;
  localparam logic [OP_W-1:0] OP_POP   = 4'd15;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x W register file: two combinational read ports, a load port and a
// writeback port; writeback wins when both target the same entry.
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  parameter  int W     = DEF_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr_i,
  output logic [W-1:0]  ra_data_o,
  input  logic [AW-1:0] rb_addr_i,
  output logic [W-1:0]  rb_data_o,
  input  logic          ld_en_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [W-1:0]  ld_data_i,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [W-1:0]  wb_data_i
);

  logic [W-1:0] rf_q [NREGS];
  logic [W-1:0] rf_d [NREGS];

  // Writeback is applied last so it overrides a same-address load.
  always_comb begin
    rf_d = rf_q;
    if (ld_en_i) rf_d[ld_addr_i] = ld_data_i;
    if (wb_en_i) rf_d[wb_addr_i] = wb_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign ra_data_o = rf_q[ra_addr_i];
  assign rb_data_o = rf_q[rb_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Serializing front end for the external ALU: accept, execute, respond.
// Defining ALU_SEQ_FLAGS_EN adds registered res_zero/res_neg outputs.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  parameter  int W     = DEF_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OP_W-1:0] instr_op,
  input  logic [AW-1:0]   instr_rd,
  input  logic [AW-1:0]   instr_rs,
  input  logic [AW-1:0]   instr_rt,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [W-1:0]    ld_data,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [W-1:0]    alu_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic [AW-1:0]   res_rd
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic            res_zero,
  output logic            res_neg
`endif
);

  seq_state_e      state_q, state_d;
  logic            accept, capture, wb_en;
  logic [W-1:0]    rs_data, rt_data;
  logic [W-1:0]    alu_a_q, alu_b_q, res_data_q;
  logic [OP_W-1:0] alu_op_q;
  logic [AW-1:0]   res_rd_q;

  alu_regfile #(.NREGS(NREGS), .W(W)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (instr_rs),
    .ra_data_o (rs_data),
    .rb_addr_i (instr_rt),
    .rb_data_o (rt_data),
    .ld_en_i   (ld_en),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .wb_en_i   (wb_en),
    .wb_addr_i (res_rd_q),
    .wb_data_i (res_data_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    wb_en   = 1'b0;
    case (state_q)
      ST_IDLE: if (instr_valid) begin
        accept  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (res_ready) begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs come from state alone, never from the inputs.
  assign instr_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
    end else begin
      if (accept) begin
        alu_a_q  <= rs_data;
        alu_b_q  <= rt_data;
        alu_op_q <= instr_op;
        res_rd_q <= instr_rd;
      end
      if (capture) res_data_q <= alu_out;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign res_data = res_data_q;
  assign res_rd   = res_rd_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic res_zero_q, res_neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
    end else if (capture) begin
      res_zero_q <= (alu_out == '0);
      res_neg_q  <= alu_out[W-1];
    end
  end

  assign res_zero = res_zero_q;
  assign res_neg  = res_neg_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ALU beside the DUT, opcode vector
// table, scoreboard of results, and hand sequences for corner cases.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int NREGS = 8;
  localparam int W     = 8;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr_valid, instr_ready;
  logic [3:0]      instr_op;
  logic [AW-1:0]   instr_rd, instr_rs, instr_rt;
  logic            ld_en;
  logic [AW-1:0]   ld_addr;
  logic [W-1:0]    ld_data;
  logic [W-1:0]    alu_a, alu_b, alu_out;
  logic [3:0]      alu_op;
  logic            res_valid, res_ready;
  logic [W-1:0]    res_data;
  logic [AW-1:0]   res_rd;
`ifdef ALU_SEQ_FLAGS_EN
  logic            res_zero, res_neg;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl #(.NREGS(NREGS), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd)
`ifdef ALU_SEQ_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  // Behavioural stand-in for the 16-op ALU that sits beside the DUT.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] r;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_MUL:   r = a * b;
      OP_DIV:   r = (b == 8'd0) ? 8'hFF : a / b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_SHL:   r = a << b[2:0];
      OP_SRL:   r = a >> b[2:0];
      OP_SRA:   r = 8'($signed(a) >>> b[2:0]);
      OP_INC4:  r = a + 8'd4;
      OP_DEC4:  r = a - 8'd4;
      OP_POP:   r = 8'($countones(a));
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign alu_out = alu_f(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [AW-1:0] rd;
  } res_t;

  res_t sbq[$];
  res_t mon_e;
  int   acc_cyc[$];
  int   n_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Handshakes are decided at the next rising edge; inputs are stable here.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h expected=none", res_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_res_data", {24'd0, res_data}, {24'd0, mon_e.data});
        chk("sb_res_rd", {29'd0, res_rd}, {29'd0, mon_e.rd});
      end
    end
    if (rst_n && instr_valid && instr_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [AW-1:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Offer an instruction, wait for acceptance, then check the operand latch.
  task automatic issue(input string nm, input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic [W-1:0] exp);
    int n = 0;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    while (!instr_ready && n < 20) begin tick(); n++; end
    if (!instr_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=not_ready expected=ready", nm);
      instr_valid = 1'b0;
      return;
    end
    sbq.push_back(res_t'{data: exp, rd: rd});
    tick();
    instr_valid = 1'b0;
    chk({nm, "_alu_a"}, {24'd0, alu_a}, {24'd0, ea});
    chk({nm, "_alu_b"}, {24'd0, alu_b}, {24'd0, eb});
    chk({nm, "_alu_op"}, {28'd0, alu_op}, {28'd0, op});
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!instr_ready && n < 50) begin tick(); n++; end
    if (!instr_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout actual=busy expected=idle", nm);
    end
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] rs, rt, rd;
    logic [W-1:0]  a, b, exp;
  } vec_t;

  vec_t vt[16];

  initial begin
    int n0;
    vt[0]  = '{OP_ADD,   3'd1, 3'd2, 3'd3, 8'h05, 8'h03, 8'h08};
    vt[1]  = '{OP_SUB,   3'd2, 3'd3, 3'd4, 8'h02, 8'h03, 8'hFF};
    vt[2]  = '{OP_MUL,   3'd3, 3'd4, 3'd5, 8'h10, 8'h11, 8'h10};
    vt[3]  = '{OP_DIV,   3'd4, 3'd5, 3'd6, 8'h64, 8'h07, 8'h0E};
    vt[4]  = '{OP_AND,   3'd5, 3'd6, 3'd7, 8'hF0, 8'h3C, 8'h30};
    vt[5]  = '{OP_OR,    3'd6, 3'd7, 3'd0, 8'hF0, 8'h0F, 8'hFF};
    vt[6]  = '{OP_XOR,   3'd7, 3'd0, 3'd1, 8'hAA, 8'hFF, 8'h55};
    vt[7]  = '{OP_NOT,   3'd0, 3'd1, 3'd2, 8'h0F, 8'h00, 8'hF0};
    vt[8]  = '{OP_PASSA, 3'd1, 3'd2, 3'd3, 8'h12, 8'h34, 8'h12};
    vt[9]  = '{OP_PASSB, 3'd2, 3'd3, 3'd4, 8'h12, 8'h34, 8'h34};
    vt[10] = '{OP_SHL,   3'd3, 3'd4, 3'd5, 8'h81, 8'h01, 8'h02};
    vt[11] = '{OP_SRL,   3'd4, 3'd5, 3'd6, 8'h80, 8'h03, 8'h10};
    vt[12] = '{OP_SRA,   3'd5, 3'd6, 3'd7, 8'h80, 8'h01, 8'hC0};
    vt[13] = '{OP_INC4,  3'd6, 3'd7, 3'd0, 8'hFE, 8'h00, 8'h02};
    vt[14] = '{OP_DEC4,  3'd7, 3'd0, 3'd1, 8'h02, 8'h00, 8'hFE};
    vt[15] = '{OP_POP,   3'd0, 3'd1, 3'd2, 8'hB7, 8'h00, 8'h06};

    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0;
    instr_rd = '0; instr_rs = '0; instr_rt = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; res_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    chk("rst_res_rd", {29'd0, res_rd}, 32'd0);

    // Basic add with a stalled consumer; a second offer must not be taken.
    ld(3'd1, 8'd5);
    ld(3'd2, 8'd3);
    res_ready = 1'b0;
    issue("add", OP_ADD, 3'd3, 3'd1, 3'd2, 8'd5, 8'd3, 8'd8);
    chk("add_exec_no_valid", {31'd0, res_valid}, 32'd0);
    tick();
    instr_valid = 1'b1; instr_op = OP_SUB; instr_rd = 3'd7; instr_rs = 3'd1; instr_rt = 3'd2;
    n0 = n_acc;
    for (int k = 0; k < 5; k++) begin
      chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_res_data", {24'd0, res_data}, 32'd8);
      chk("hold_res_rd", {29'd0, res_rd}, 32'd3);
      chk("hold_instr_ready", {31'd0, instr_ready}, 32'd0);
      tick();
    end
    chk("hold_no_accept", n_acc, n0);
    instr_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("add");
    issue("rd_r3", OP_PASSA, 3'd4, 3'd3, 3'd3, 8'd8, 8'd8, 8'd8);
    wait_idle("rd_r3");

    // Opcode vector table with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      ld(vt[i].rs, vt[i].a);
      ld(vt[i].rt, vt[i].b);
      issue($sformatf("vec%0d", i), vt[i].op, vt[i].rd, vt[i].rs, vt[i].rt,
            vt[i].a, vt[i].b, vt[i].exp);
      tick();
      chk($sformatf("vec%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
      wait_idle($sformatf("vec%0d", i));
    end

    // Writeback beats a same-cycle load to the same register.
    ld(3'd4, 8'h08);
    ld(3'd5, 8'h08);
    res_ready = 1'b0;
    issue("coll", OP_ADD, 3'd6, 3'd4, 3'd5, 8'h08, 8'h08, 8'h10);
    tick();
    res_ready = 1'b1; ld_en = 1'b1; ld_addr = 3'd6; ld_data = 8'hAA;
    tick();
    ld_en = 1'b0;
    wait_idle("coll");
    issue("coll_rd", OP_PASSA, 3'd0, 3'd6, 3'd6, 8'h10, 8'h10, 8'h10);
    wait_idle("coll_rd");

    // Writeback and load to different registers both land.
    res_ready = 1'b0;
    issue("dual", OP_ADD, 3'd3, 3'd4, 3'd5, 8'h08, 8'h08, 8'h10);
    tick();
    res_ready = 1'b1; ld_en = 1'b1; ld_addr = 3'd7; ld_data = 8'h55;
    tick();
    ld_en = 1'b0;
    wait_idle("dual");
    issue("dual_rd", OP_PASSB, 3'd0, 3'd3, 3'd7, 8'h10, 8'h55, 8'h55);
    wait_idle("dual_rd");

    // A load in the acceptance cycle is invisible to that instruction.
    ld(3'd1, 8'h11);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'h99;
    issue("ldacc", OP_PASSA, 3'd2, 3'd1, 3'd0, 8'h11, 8'h55, 8'h11);
    ld_en = 1'b0;
    wait_idle("ldacc");
    issue("ldacc_rd", OP_PASSA, 3'd2, 3'd1, 3'd0, 8'h99, 8'h55, 8'h99);
    wait_idle("ldacc_rd");

    // Back-to-back dependent pair, issued as fast as the FSM allows.
    ld(3'd1, 8'h80);
    ld(3'd2, 8'h01);
    issue("b2b_sra", OP_SRA, 3'd1, 3'd1, 3'd2, 8'h80, 8'h01, 8'hC0);
    issue("b2b_pop", OP_POP, 3'd4, 3'd1, 3'd2, 8'hC0, 8'h01, 8'h02);
    wait_idle("b2b");
    chk("b2b_interval", acc_cyc[$] - acc_cyc[$-1], 32'd3);

`ifdef ALU_SEQ_FLAGS_EN
    ld(3'd1, 8'd3);
    ld(3'd2, 8'd3);
    issue("flz", OP_SUB, 3'd3, 3'd1, 3'd2, 8'd3, 8'd3, 8'd0);
    tick();
    chk("flz_zero", {31'd0, res_zero}, 32'd1);
    chk("flz_neg", {31'd0, res_neg}, 32'd0);
    wait_idle("flz");
    ld(3'd1, 8'd2);
    issue("fln", OP_SUB, 3'd3, 3'd1, 3'd2, 8'd2, 8'd3, 8'hFF);
    tick();
    chk("fln_data", {24'd0, res_data}, 32'hFF);
    chk("fln_zero", {31'd0, res_zero}, 32'd0);
    chk("fln_neg", {31'd0, res_neg}, 32'd1);
    wait_idle("fln");
`endif

    // Reset asserted mid-EXEC discards the in-flight result.
    ld(3'd0, 8'h33);
    issue("rstx", OP_PASSA, 3'd0, 3'd0, 3'd0, 8'h33, 8'h33, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("rstx_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rstx_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rstx_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rstx_alu_b", {24'd0, alu_b}, 32'd0);
    chk("rstx_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rstx_res_data", {24'd0, res_data}, 32'd0);
    chk("rstx_res_rd", {29'd0, res_rd}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("rstx_post_ready", {31'd0, instr_ready}, 32'd1);
      chk("rstx_post_valid", {31'd0, res_valid}, 32'd0);
      tick();
    end
    issue("rstx_rd", OP_PASSA, 3'd1, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
    wait_idle("rstx_rd");

    chk("sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
